// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the two writeback sources, the register file write
// port and decode's hazard logic, shared by rf_write_arbiter and its users.
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [3:0]            alu_reg;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [3:0]            mem_reg;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [3:0]            DstReg;
  logic                  WriteReg;
  logic [DATA_WIDTH-1:0] DstData;
  logic [15:0]           pending;
  logic                  idle;

  // Requesters: drive writes, observe readies, the write port and status.
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, DstReg, WriteReg, DstData, pending, idle
  );

  // Arbiter side: accepts writes and drives the register file port.
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, DstReg, WriteReg, DstData, pending, idle
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the ALU (port 0) and the
// load unit (port 1). Each source owns a small FIFO; a round-robin arbiter
// drains the FIFO heads into a registered write stage. A pending mask lets
// decode stall on RAW hazards against queued or in-flight writes.
module rf_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 16,
  parameter bit DROP_R0    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage and pointers; pointer MSB is the wrap bit.
  logic [3:0]            regMem  [2][DEPTH];
  logic [DATA_WIDTH-1:0] dataMem [2][DEPTH];
  logic [AW:0]           wrPtr   [2];
  logic [AW:0]           rdPtr   [2];

  logic [1:0]            empty;
  logic [1:0]            full;
  logic [1:0]            push;
  logic [1:0]            grant;
  logic                  anyGrant;
  logic                  grantPort;
  logic [3:0]            headReg;
  logic [DATA_WIDTH-1:0] headData;

  logic                  lastGrant;
  logic                  readyEn;
  logic                  writeRegQ;
  logic [3:0]            dstRegQ;
  logic [DATA_WIDTH-1:0] dstDataQ;

  logic [15:0]           pendingMask;
  logic [AW-1:0]         entryOff;
  logic [AW:0]           occupancy;

  // FIFO status flags and push qualification; ready never looks at a same-cycle pop.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int p = 0; p < 2; p++) begin
      empty[p] = (wrPtr[p] == rdPtr[p]);
      full[p]  = (wrPtr[p][AW-1:0] == rdPtr[p][AW-1:0]) && (wrPtr[p][AW] != rdPtr[p][AW]);
    end
    push[0] = bus.alu_valid && readyEn && !full[0];
    push[1] = bus.mem_valid && readyEn && !full[1];
  end

  // Round-robin choice between FIFO heads; contention goes to the port that lost last time.
  always_comb begin
    anyGrant  = !empty[0] || !empty[1];
    grantPort = 1'b0;
    if (!empty[0] && !empty[1]) begin
      grantPort = ~lastGrant;
    end else if (!empty[1]) begin
      grantPort = 1'b1;
    end
    grant = '0;
    if (anyGrant) begin
      grant[grantPort] = 1'b1;
    end
    headReg  = regMem[grantPort][rdPtr[grantPort][AW-1:0]];
    headData = dataMem[grantPort][rdPtr[grantPort][AW-1:0]];
  end

  // FIFO payload storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push[0]) begin
      regMem[0][wrPtr[0][AW-1:0]]  <= bus.alu_reg;
      dataMem[0][wrPtr[0][AW-1:0]] <= bus.alu_data;
    end
    if (push[1]) begin
      regMem[1][wrPtr[1][AW-1:0]]  <= bus.mem_reg;
      dataMem[1][wrPtr[1][AW-1:0]] <= bus.mem_data;
    end
  end

  // Pointer advance on push and on grant-driven pop; reset empties both FIFOs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr[0] <= '0;
      wrPtr[1] <= '0;
      rdPtr[0] <= '0;
      rdPtr[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wrPtr[p] <= wrPtr[p] + 1'b1;
        if (grant[p]) rdPtr[p] <= rdPtr[p] + 1'b1;
      end
    end
  end

  // Registered write stage plus arbitration history and post-reset ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeRegQ <= 1'b0;
      dstRegQ   <= '0;
      dstDataQ  <= '0;
      lastGrant <= 1'b1;
      readyEn   <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (anyGrant) begin
        dstRegQ   <= headReg;
        dstDataQ  <= headData;
        writeRegQ <= !(DROP_R0 && (headReg == 4'd0));
        lastGrant <= grantPort;
      end else begin
        writeRegQ <= 1'b0;
      end
    end
  end

  // Hazard mask over every live FIFO entry plus the write currently on the port.
  always_comb begin
    pendingMask = '0;
    entryOff    = '0;
    occupancy   = '0;
    for (int p = 0; p < 2; p++) begin
      occupancy = wrPtr[p] - rdPtr[p];
      for (int i = 0; i < DEPTH; i++) begin
        entryOff = AW'(i) - rdPtr[p][AW-1:0];
        if ({1'b0, entryOff} < occupancy) begin
          pendingMask[regMem[p][i]] = 1'b1;
        end
      end
    end
    if (writeRegQ) begin
      pendingMask[dstRegQ] = 1'b1;
    end
    if (DROP_R0) begin
      pendingMask[0] = 1'b0;
    end
  end

  assign bus.alu_ready = readyEn && !full[0];
  assign bus.mem_ready = readyEn && !full[1];
  assign bus.DstReg    = dstRegQ;
  assign bus.WriteReg  = writeRegQ;
  assign bus.DstData   = dstDataQ;
  assign bus.pending   = pendingMask;
  assign bus.idle      = empty[0] && empty[1] && !writeRegQ;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: per-scenario tasks plus a
// scoreboard that matches every register-file write against the oldest
// outstanding accepted write of one of the two sources.
module tb_rf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int DATA_WIDTH = 16;
  localparam bit DROP_R0    = 1'b1;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  logic [19:0] expA[$];
  logic [19:0] expM[$];

  rf_write_arbiter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  rf_write_arbiter #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DROP_R0(DROP_R0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Scoreboard: each write must match the head of the ALU or load expectation queue.
  always @(negedge clk) begin
    if (rst && bus.WriteReg) begin
      compared++;
      if (expA.size() > 0 && expA[0] == {bus.DstReg, bus.DstData}) begin
        void'(expA.pop_front());
      end else if (expM.size() > 0 && expM[0] == {bus.DstReg, bus.DstData}) begin
        void'(expM.pop_front());
      end else begin
        mismatched++;
        $display("[TB] FAIL scoreboard_write: got reg %0d data 0x%04h, expected alu head 0x%05h (n=%0d) or mem head 0x%05h (n=%0d)",
                 bus.DstReg, bus.DstData, (expA.size() > 0) ? expA[0] : 20'h0, expA.size(),
                 (expM.size() > 0) ? expM[0] : 20'h0, expM.size());
      end
    end
  end

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveIdle();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = 4'd0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_reg   = 4'd0;
    bus.mem_data  = '0;
  endtask

  // One clock: note handshakes before the edge, record accepted writes, return at negedge.
  task automatic applyStimulus(output logic accA, output logic accM);
    accA = bus.alu_valid && bus.alu_ready;
    accM = bus.mem_valid && bus.mem_ready;
    @(posedge clk);
    if (accA && (!DROP_R0 || bus.alu_reg != 4'd0)) expA.push_back({bus.alu_reg, bus.alu_data});
    if (accM && (!DROP_R0 || bus.mem_reg != 4'd0)) expM.push_back({bus.mem_reg, bus.mem_data});
    @(negedge clk);
  endtask

  task automatic doReset();
    driveIdle();
    rst = 1'b0;
    expA.delete();
    expM.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    driveIdle();
    repeat (2) @(negedge clk);
    compared += 7;
    if (bus.WriteReg !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_writereg: got %b expected 0", bus.WriteReg); end
    if (bus.DstReg !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_dstreg: got %0d expected 0", bus.DstReg); end
    if (bus.DstData !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_dstdata: got 0x%04h expected 0x0000", bus.DstData); end
    if (bus.pending !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_pending: got 0x%04h expected 0x0000", bus.pending); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_idle: got %b expected 1", bus.idle); end
    if (bus.alu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_alu_ready: got %b expected 0", bus.alu_ready); end
    if (bus.mem_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_ready: got %b expected 0", bus.mem_ready); end
    rst = 1'b1;
    @(negedge clk);
    compared += 3;
    if (bus.alu_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_alu_ready: got %b expected 1", bus.alu_ready); end
    if (bus.mem_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_mem_ready: got %b expected 1", bus.mem_ready); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL release_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_single_write();
    logic accA, accM;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 4'd5;
    bus.alu_data  = 16'hBEEF;
    applyStimulus(accA, accM);
    driveIdle();
    compared += 4;
    if (accA !== 1'b1) begin mismatched++; $display("[TB] FAIL single_accept: got %b expected 1", accA); end
    if (bus.pending !== 16'h0020) begin mismatched++; $display("[TB] FAIL single_pending_q: got 0x%04h expected 0x0020", bus.pending); end
    if (bus.WriteReg !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_write: got %b expected 0", bus.WriteReg); end
    if (bus.idle !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy: got %b expected 0", bus.idle); end
    applyStimulus(accA, accM);
    compared += 4;
    if (bus.WriteReg !== 1'b1) begin mismatched++; $display("[TB] FAIL single_writereg: got %b expected 1", bus.WriteReg); end
    if (bus.DstReg !== 4'd5) begin mismatched++; $display("[TB] FAIL single_dstreg: got %0d expected 5", bus.DstReg); end
    if (bus.DstData !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL single_dstdata: got 0x%04h expected 0xBEEF", bus.DstData); end
    if (bus.pending !== 16'h0020) begin mismatched++; $display("[TB] FAIL single_pending_w: got 0x%04h expected 0x0020", bus.pending); end
    applyStimulus(accA, accM);
    compared += 3;
    if (bus.WriteReg !== 1'b0) begin mismatched++; $display("[TB] FAIL single_write_end: got %b expected 0", bus.WriteReg); end
    if (bus.pending !== 16'h0) begin mismatched++; $display("[TB] FAIL single_pending_clr: got 0x%04h expected 0x0000", bus.pending); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL single_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_contention();
    logic [3:0] aluRegs [3]  = '{4'd1, 4'd2, 4'd3};
    logic [3:0] memRegs [3]  = '{4'd9, 4'd10, 4'd11};
    logic [3:0] expOrder [6] = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
    logic [3:0] order[$];
    logic [3:0] got;
    logic accA, accM;
    int ai = 0;
    int mi = 0;
    int gaps = 0;
    doReset();
    for (int cyc = 0; cyc < 40 && order.size() < 6; cyc++) begin
      bus.alu_valid = (ai < 3);
      if (ai < 3) begin bus.alu_reg = aluRegs[ai]; bus.alu_data = 16'hA000 + 16'(ai); end
      bus.mem_valid = (mi < 3);
      if (mi < 3) begin bus.mem_reg = memRegs[mi]; bus.mem_data = 16'hB000 + 16'(mi); end
      applyStimulus(accA, accM);
      if (accA) ai++;
      if (accM) mi++;
      if (bus.WriteReg) order.push_back(bus.DstReg);
      else if (order.size() > 0) gaps++;
    end
    driveIdle();
    compared += 2;
    if (order.size() != 6) begin mismatched++; $display("[TB] FAIL contention_count: got %0d expected 6", order.size()); end
    if (gaps != 0) begin mismatched++; $display("[TB] FAIL contention_gaps: got %0d expected 0", gaps); end
    for (int k = 0; k < 6; k++) begin
      got = (k < order.size()) ? order[k] : 4'hF;
      compared++;
      if (got !== expOrder[k]) begin mismatched++; $display("[TB] FAIL contention_order[%0d]: got %0d expected %0d", k, got, expOrder[k]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] memOut[$];
    logic [15:0] got;
    logic accA, accM;
    int ai = 0;
    int mi = 0;
    int firstStall = -1;
    for (int cyc = 0; cyc < 300 && memOut.size() < 10; cyc++) begin
      bus.alu_valid = (mi < 10);
      bus.alu_reg   = 4'd12;
      bus.alu_data  = 16'hC000 + 16'(ai);
      bus.mem_valid = (mi < 10);
      bus.mem_reg   = 4'd7;
      bus.mem_data  = 16'(mi + 1);
      if (firstStall < 0 && bus.mem_valid && !bus.mem_ready) firstStall = mi;
      applyStimulus(accA, accM);
      if (accA) ai++;
      if (accM) mi++;
      if (bus.WriteReg && bus.DstReg == 4'd7) memOut.push_back(bus.DstData);
    end
    driveIdle();
    for (int k = 0; k < 20 && !bus.idle; k++) applyStimulus(accA, accM);
    compared += 5;
    if (firstStall != 2) begin mismatched++; $display("[TB] FAIL wrap_backpressure: got stall after %0d accepts expected 2", firstStall); end
    if (memOut.size() != 10) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d expected 10", memOut.size()); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_drain_idle: got %b expected 1", bus.idle); end
    if (expA.size() != 0) begin mismatched++; $display("[TB] FAIL wrap_alu_lost: got %0d outstanding expected 0", expA.size()); end
    if (expM.size() != 0) begin mismatched++; $display("[TB] FAIL wrap_mem_lost: got %0d outstanding expected 0", expM.size()); end
    for (int k = 0; k < 10; k++) begin
      got = (k < memOut.size()) ? memOut[k] : 16'hFFFF;
      compared++;
      if (got !== 16'(k + 1)) begin mismatched++; $display("[TB] FAIL wrap_order[%0d]: got 0x%04h expected 0x%04h", k, got, 16'(k + 1)); end
    end
  endtask

  task automatic test_drop_r0();
    logic accA, accM;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 4'd0;
    bus.alu_data  = 16'h1234;
    applyStimulus(accA, accM);
    driveIdle();
    compared += 3;
    if (bus.pending !== 16'h0) begin mismatched++; $display("[TB] FAIL drop_pending_q: got 0x%04h expected 0x0000", bus.pending); end
    if (bus.idle !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_busy: got %b expected 0", bus.idle); end
    if (accA !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_accept: got %b expected 1", accA); end
    applyStimulus(accA, accM);
    compared += 5;
    if (bus.WriteReg !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_writereg: got %b expected 0", bus.WriteReg); end
    if (bus.DstReg !== 4'd0) begin mismatched++; $display("[TB] FAIL drop_dstreg: got %0d expected 0", bus.DstReg); end
    if (bus.DstData !== 16'h1234) begin mismatched++; $display("[TB] FAIL drop_dstdata: got 0x%04h expected 0x1234", bus.DstData); end
    if (bus.pending !== 16'h0) begin mismatched++; $display("[TB] FAIL drop_pending_w: got 0x%04h expected 0x0000", bus.pending); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_reset_mid();
    logic accA, accM;
    int stale = 0;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 4'd2;
    bus.alu_data  = 16'hD000;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 4'd6;
    bus.mem_data  = 16'hE000;
    for (int cyc = 0; cyc < 10 && !bus.WriteReg; cyc++) applyStimulus(accA, accM);
    compared += 2;
    if (bus.WriteReg !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_setup: got %b expected 1", bus.WriteReg); end
    if ((bus.pending != 16'h0) !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_pending_set: got 0x%04h expected nonzero", bus.pending); end
    #2;
    rst = 1'b0;
    #1;
    expA.delete();
    expM.delete();
    compared += 4;
    if (bus.WriteReg !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_writereg: got %b expected 0", bus.WriteReg); end
    if (bus.pending !== 16'h0) begin mismatched++; $display("[TB] FAIL midreset_pending: got 0x%04h expected 0x0000", bus.pending); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_idle: got %b expected 1", bus.idle); end
    if (bus.alu_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_ready: got %b expected 0", bus.alu_ready); end
    @(negedge clk);
    driveIdle();
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      applyStimulus(accA, accM);
      if (bus.WriteReg) stale++;
    end
    compared += 4;
    if (stale != 0) begin mismatched++; $display("[TB] FAIL midreset_stale: got %0d writes expected 0", stale); end
    if (bus.idle !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_after_idle: got %b expected 1", bus.idle); end
    if (bus.alu_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_alu_ready: got %b expected 1", bus.alu_ready); end
    if (bus.mem_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_mem_ready: got %b expected 1", bus.mem_ready); end
  endtask

  // Scenario sequence followed by the one-line summary.
  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_wrap();
    test_drop_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
